// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared combinational ALU (IDLE -> ISSUE -> CAPTURE).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [3:0] req0_mode,
    input  logic [3:0] req1_mode,
    input  logic [7:0] req0_op1,
    input  logic [7:0] req0_op2,
    input  logic [7:0] req1_op1,
    input  logic [7:0] req1_op2,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [7:0] rsp_out,
    output logic [3:0] rsp_flags,
    output logic       alu_e,
    output logic [3:0] alu_mode,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    localparam logic [1:0] LP_WAIT = 2'(WAIT_CYCLES);
    state_t     r_state, w_next;
    logic [1:0] r_cnt;
    logic       r_owner, r_alu_e, r_rsp0_valid, r_rsp1_valid;
    logic [3:0] r_alu_mode, r_rsp_flags;
    logic [7:0] r_alu_op1, r_alu_op2, r_rsp_out;
    logic       w_gnt0, w_gnt1, w_idle, w_hs, w_last;

    assign w_idle = (r_state == IDLE);
    assign w_hs   = w_idle && (req0_valid || req1_valid);
    assign w_last = (r_state == ISSUE) && (r_cnt == 2'd0);
`ifdef ALU_ARB_RR_EN
    // r_ptr names the favored requester; each grant hands the favor to the other one
    logic r_ptr;
    assign w_gnt0 = req0_valid && (!req1_valid || !r_ptr);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ptr <= 1'b0;
        else if (w_hs) r_ptr <= ~w_gnt1;
`else
    assign w_gnt0 = req0_valid;
`endif
    assign w_gnt1     = req1_valid && !w_gnt0;
    assign req0_ready = w_idle && w_gnt0;
    assign req1_ready = w_idle && w_gnt1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_out    = r_rsp_out;
    assign rsp_flags  = r_rsp_flags;
    assign alu_e      = r_alu_e;
    assign alu_mode   = r_alu_mode;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (w_hs) w_next = ISSUE;
        else if (w_last) w_next = CAPTURE;
        else if (r_state == CAPTURE) w_next = IDLE;
    end

    // result is sampled on the last ISSUE edge so rsp_valid and rsp_out appear together in CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 2'd0;
            r_owner      <= 1'b0;
            r_alu_e      <= 1'b0;
            r_alu_mode   <= 4'd0;
            r_alu_op1    <= 8'd0;
            r_alu_op2    <= 8'd0;
            r_rsp_out    <= 8'd0;
            r_rsp_flags  <= 4'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            if (w_hs) begin
                r_alu_e    <= 1'b1;
                r_alu_mode <= w_gnt1 ? req1_mode : req0_mode;
                r_alu_op1  <= w_gnt1 ? req1_op1 : req0_op1;
                r_alu_op2  <= w_gnt1 ? req1_op2 : req0_op2;
                r_owner    <= w_gnt1;
                r_cnt      <= LP_WAIT;
            end else if (w_last) begin
                r_alu_e      <= 1'b0;
                r_rsp_out    <= alu_out;
                r_rsp_flags  <= alu_flags;
                r_rsp0_valid <= !r_owner;
                r_rsp1_valid <= r_owner;
            end else if (r_state == ISSUE) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, directed corner sequences and randomized traffic against a
// transaction-level model; dut_a uses WAIT_CYCLES=0, dut_b uses WAIT_CYCLES=3.
module tb_alu_arbiter;
    localparam int W_A = 0;
    localparam int W_B = 3;
    typedef struct { logic [3:0] mode; logic [7:0] op1, op2, res; logic [3:0] fl; } vec_t;
    typedef struct { int due; logic owner; logic [7:0] res; logic [3:0] fl; } rsp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_v0, a_v1, a_r0, a_r1, a_rv0, a_rv1, a_e;
    logic [3:0] a_m0, a_m1, a_rfl, a_mode, a_afl;
    logic [7:0] a_x0, a_y0, a_x1, a_y1, a_rout, a_op1, a_op2, a_aout;
    logic       b_v0, b_v1, b_r0, b_r1, b_rv0, b_rv1, b_e;
    logic [3:0] b_m0, b_m1, b_rfl, b_mode, b_afl;
    logic [7:0] b_x0, b_y0, b_x1, b_y1, b_rout, b_op1, b_op2, b_aout;
    int checks = 0, errors = 0;

    // reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass op1; returns {result, Z, C, S, O}
    function automatic logic [11:0] alu_f(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic       o;
        o = 1'b0;
        case (m)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; o = (a[7] == b[7]) && (s[7] != a[7]); end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; o = (a[7] != b[7]) && (s[7] != a[7]); end
            4'd2: s = {1'b0, a & b};
            4'd3: s = {1'b0, a | b};
            4'd4: s = {1'b0, a ^ b};
            default: s = {1'b0, a};
        endcase
        return {s[7:0], s[7:0] == 8'h00, s[8], s[7], o};
    endfunction

    always_comb {a_aout, a_afl} = alu_f(a_mode, a_op1, a_op2);
    always_comb {b_aout, b_afl} = alu_f(b_mode, b_op1, b_op2);

    alu_arbiter #(.WAIT_CYCLES(W_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_v0), .req1_valid(a_v1), .req0_mode(a_m0), .req1_mode(a_m1),
        .req0_op1(a_x0), .req0_op2(a_y0), .req1_op1(a_x1), .req1_op2(a_y1),
        .req0_ready(a_r0), .req1_ready(a_r1), .rsp0_valid(a_rv0), .rsp1_valid(a_rv1),
        .rsp_out(a_rout), .rsp_flags(a_rfl), .alu_e(a_e), .alu_mode(a_mode),
        .alu_op1(a_op1), .alu_op2(a_op2), .alu_out(a_aout), .alu_flags(a_afl)
    );

    alu_arbiter #(.WAIT_CYCLES(W_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_v0), .req1_valid(b_v1), .req0_mode(b_m0), .req1_mode(b_m1),
        .req0_op1(b_x0), .req0_op2(b_y0), .req1_op1(b_x1), .req1_op2(b_y1),
        .req0_ready(b_r0), .req1_ready(b_r1), .rsp0_valid(b_rv0), .rsp1_valid(b_rv1),
        .rsp_out(b_rout), .rsp_flags(b_rfl), .alu_e(b_e), .alu_mode(b_mode),
        .alu_op1(b_op1), .alu_op2(b_op2), .alu_out(b_aout), .alu_flags(b_afl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_alu_e"}, a_e, 0);
        chk({tag, "_alu_mode"}, a_mode, 0);
        chk({tag, "_alu_op1"}, a_op1, 0);
        chk({tag, "_alu_op2"}, a_op2, 0);
        chk({tag, "_rsp_out"}, a_rout, 0);
        chk({tag, "_rsp_flags"}, a_rfl, 0);
        chk({tag, "_rsp0"}, a_rv0, 0);
        chk({tag, "_rsp1"}, a_rv1, 0);
    endtask

    initial begin
        vec_t       tv[9];
        int         order[$];
        int         exp_o[6];
        int         n0, n1, ecnt, rcyc, busy;
        rsp_t       q[$];
        rsp_t       t;
        logic       mptr, hold0, hold1, e0, e1, w0, w1, idle;
        logic [11:0] r;
        {a_v0, a_v1, a_m0, a_m1, a_x0, a_y0, a_x1, a_y1} = '0;
        {b_v0, b_v1, b_m0, b_m1, b_x0, b_y0, b_x1, b_y1} = '0;
        tv[0] = '{4'd0, 8'h7F, 8'h01, 8'h80, 4'b0011};
        tv[1] = '{4'd0, 8'hFF, 8'h01, 8'h00, 4'b1100};
        tv[2] = '{4'd1, 8'h05, 8'h05, 8'h00, 4'b1000};
        tv[3] = '{4'd1, 8'h00, 8'h01, 8'hFF, 4'b0110};
        tv[4] = '{4'd1, 8'h80, 8'h01, 8'h7F, 4'b0001};
        tv[5] = '{4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        tv[6] = '{4'd3, 8'hF0, 8'h0F, 8'hFF, 4'b0010};
        tv[7] = '{4'd4, 8'hAA, 8'hAA, 8'h00, 4'b1000};
        tv[8] = '{4'd7, 8'h9C, 8'h00, 8'h9C, 4'b0010};
        repeat (3) nxt;
        #1;
        chk_a_zero("reset");
        chk("reset_b_alu_e", b_e, 0);
        chk("reset_b_rsp1", b_rv1, 0);
        rst_n = 1'b1;
        nxt;
        // WAIT_CYCLES=3: alu_e for 4 cycles, response 5 cycles after the handshake
        b_v1 = 1'b1; b_m1 = 4'd1; b_x1 = 8'h05; b_y1 = 8'h05;
        #1;
        chk("b_ready1", b_r1, 1);
        chk("b_ready0", b_r0, 0);
        ecnt = 0; rcyc = -1;
        for (int k = 1; k <= 7; k++) begin
            nxt;
            b_v1 = 1'b0;
            #1;
            if (b_e) ecnt++;
            if (b_rv1) begin
                rcyc = k;
                chk("b_rsp_out", b_rout, 8'h00);
                chk("b_rsp_z", b_rfl[3], 1);
            end
            chk("b_rsp0", b_rv0, 0);
        end
        chk("b_alu_e_cycles", ecnt, 4);
        chk("b_rsp1_cycle", rcyc, 5);
        nxt;
        // table: requester 0 alone, operands scrambled right after the handshake
        foreach (tv[i]) begin
            a_v0 = 1'b1; a_m0 = tv[i].mode; a_x0 = tv[i].op1; a_y0 = tv[i].op2;
            #1;
            chk("tv_ready0", a_r0, 1);
            chk("tv_ready1", a_r1, 0);
            nxt;
            a_v0 = 1'b0; a_m0 = 4'hF; a_x0 = 8'hFF; a_y0 = 8'hFF;
            #1;
            chk("tv_issue_e", a_e, 1);
            chk("tv_latched_mode", a_mode, tv[i].mode);
            chk("tv_latched_op1", a_op1, tv[i].op1);
            chk("tv_latched_op2", a_op2, tv[i].op2);
            nxt;
            #1;
            chk("tv_rsp0", a_rv0, 1);
            chk("tv_rsp1", a_rv1, 0);
            chk("tv_rsp_out", a_rout, tv[i].res);
            chk("tv_rsp_flags", a_rfl, tv[i].fl);
            chk("tv_capture_e", a_e, 0);
            nxt;
            #1;
            chk("tv_rsp0_pulse", a_rv0, 0);
            chk("tv_hold_out", a_rout, tv[i].res);
            chk("tv_idle_op1", a_op1, tv[i].op1);
            chk("tv_idle_e", a_e, 0);
        end
        // reset during ISSUE aborts the operation
        a_v0 = 1'b1; a_m0 = 4'd0; a_x0 = 8'h7F; a_y0 = 8'h01;
        #1;
        chk("rst_ready0", a_r0, 1);
        nxt;
        a_v0 = 1'b0;
        #1;
        chk("rst_pre_e", a_e, 1);
        rst_n = 1'b0;
        #1;
        chk_a_zero("midrst");
        nxt;
        nxt;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("postrst_rsp0", a_rv0, 0);
            chk("postrst_rsp1", a_rv1, 0);
            chk("postrst_e", a_e, 0);
            nxt;
        end
        // both requesters with three operations each
`ifdef ALU_ARB_RR_EN
        exp_o = '{0, 1, 0, 1, 0, 1};
`else
        exp_o = '{0, 0, 0, 1, 1, 1};
`endif
        n0 = 3; n1 = 3;
        for (int c = 0; c < 100 && order.size() < 6; c++) begin
            a_v0 = (n0 > 0); a_v1 = (n1 > 0);
            a_m0 = 4'd0; a_x0 = 8'(c); a_y0 = 8'h01;
            a_m1 = 4'd4; a_x1 = 8'(c); a_y1 = 8'h55;
            #1;
            chk("grant_exclusive", a_r0 && a_r1, 0);
            if (a_r0) begin order.push_back(0); n0--; end
            if (a_r1) begin order.push_back(1); n1--; end
            nxt;
        end
        a_v0 = 1'b0; a_v1 = 1'b0;
        chk("grant_count", order.size(), 6);
        for (int i = 0; i < 6; i++) chk("grant_order", (i < order.size()) ? order[i] : -1, exp_o[i]);
        repeat (4) nxt;
        rst_n = 1'b0;
        nxt;
        rst_n = 1'b1;
        // randomized traffic against a transaction model: latency 2+W, one op per 3+W cycles
        busy = 0; mptr = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold0 || $urandom_range(7) == 0) begin
                a_v0 = ($urandom_range(2) != 0);
                a_m0 = 4'($urandom_range(15)); a_x0 = 8'($urandom); a_y0 = 8'($urandom);
                hold0 = a_v0;
            end
            if (!hold1 || $urandom_range(7) == 0) begin
                a_v1 = ($urandom_range(2) != 0);
                a_m1 = 4'($urandom_range(15)); a_x1 = 8'($urandom); a_y1 = 8'($urandom);
                hold1 = a_v1;
            end
            #1;
            e0 = (q.size() > 0) && (q[0].due == c) && !q[0].owner;
            e1 = (q.size() > 0) && (q[0].due == c) && q[0].owner;
            chk("rnd_rsp0", a_rv0, e0);
            chk("rnd_rsp1", a_rv1, e1);
            if (e0 || e1) begin
                chk("rnd_rsp_out", a_rout, q[0].res);
                chk("rnd_rsp_flags", a_rfl, q[0].fl);
                q.delete(0);
            end
`ifdef ALU_ARB_RR_EN
            w0 = a_v0 && (!a_v1 || !mptr);
`else
            w0 = a_v0;
`endif
            w1 = a_v1 && !w0;
            idle = (busy == 0);
            chk("rnd_ready0", a_r0, idle && w0);
            chk("rnd_ready1", a_r1, idle && w1);
            chk("rnd_alu_e", a_e, busy >= 2);
            if (idle && (w0 || w1)) begin
                r = w1 ? alu_f(a_m1, a_x1, a_y1) : alu_f(a_m0, a_x0, a_y0);
                t.due = c + 2 + W_A; t.owner = w1; t.res = r[11:4]; t.fl = r[3:0];
                q.push_back(t);
                busy = 3 + W_A;
                mptr = !w1;
                if (w1) hold1 = 1'b0;
                else hold0 = 1'b0;
            end
            if (busy > 0) busy--;
            nxt;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
